wt_l15_store_splitter: RTL and testbench

Parametrised byte-enable splitter between the write-through D$ write buffer and the L1.5 adapter. Accepts one word-wide store with an arbitrary byte-enable mask and emits the shortest sequence of naturally aligned, OpenPiton-legal transactions (byte/half/word/dword) covering exactly the enabled bytes. It generalises the fixed 32/64-bit size mapping to any power-of-two data width. It also adds a greedy aligned-chunk mode, replacing the byte-by-byte fallback, which remains available as a legacy mode.

---
 rtl/wt_l15_store_splitter_pkg.sv | 49 ++++
 rtl/wt_be_chunk_sel.sv | 88 ++++++++
 rtl/wt_l15_store_splitter.sv | 111 +++++++++++
 tb/tb_wt_l15_store_splitter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_l15_store_splitter_pkg.sv
// Shared types for the write-through store splitter: L1.5 size codes,
// splitter state encoding and the legacy full-pattern size mapping.
// Purely declarative; no logic is instantiated from this file on its own.
package wt_l15_store_splitter_pkg;

    // L1.5 transaction size codes (log2 of the byte count).
    typedef enum logic [2:0] {
        L15_BYTE  = 3'b000,
        L15_HALF  = 3'b001,
        L15_WORD  = 3'b010,
        L15_DWORD = 3'b011,
        L15_QWORD = 3'b100
    } l15_size_e;

    typedef enum logic {
        SPLIT_IDLE = 1'b0,
        SPLIT_EMIT = 1'b1
    } split_state_e;

    // Widest supported store word is 128 bits.
    localparam int unsigned MAX_NB     = 16;
    localparam int unsigned MAX_LOG_NB = 4;

    // Legacy size mapping for an nb-byte word: a mask that is exactly one
    // naturally aligned half/word/dword/qword maps to that size, anything
    // else maps to BYTE (caller then walks the mask byte by byte).
    function automatic l15_size_e to_size(input logic [MAX_NB-1:0] be,
                                          input int unsigned       nb);
        l15_size_e         size;
        logic [MAX_NB-1:0] pat;
        int unsigned       span;
        size = L15_BYTE;
        for (int unsigned s = 1; s <= MAX_LOG_NB; s++) begin
            span = 1 << s;
            for (int unsigned off = 0; off < MAX_NB; off++) begin
                if ((span <= nb) && (off % span == 0) && (off + span <= nb)) begin
                    for (int unsigned b = 0; b < MAX_NB; b++) begin
                        pat[b] = (b >= off) && (b < off + span);
                    end
                    if (be == pat) begin
                        size = l15_size_e'(s[2:0]);
                    end
                end
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/wt_be_chunk_sel.sv
// Chunk selector: picks the next naturally aligned L1.5 chunk from a remaining byte mask.
// Latency: purely combinational.
// Backpressure: none; the caller holds i_rem stable while a chunk is stalled.
// Ports: i_rem remaining enables, i_first first chunk of the store (legacy only),
//        o_offset byte offset of chunk, o_size L1.5 size, o_mask chunk enables,
//        o_last no enables remain after this chunk.
module wt_be_chunk_sel
    import wt_l15_store_splitter_pkg::*;
#(
    parameter int unsigned NB          = 8,
    parameter bit          LegacySplit = 1'b0
) (
    input  logic [NB-1:0]         i_rem,
    input  logic                  i_first,
    output logic [$clog2(NB)-1:0] o_offset,
    output l15_size_e             o_size,
    output logic [NB-1:0]         o_mask,
    output logic                  o_last
);

    localparam int unsigned LW = $clog2(NB);

    int unsigned       w_idx;
    int unsigned       w_log;
    int unsigned       w_span;
    logic              w_found;
    logic              w_grow;
    logic [NB-1:0]     w_cand;
    logic [MAX_NB-1:0] w_rem_ext;
    logic              w_unused_first;

    // Greedy mode never needs to know whether this is the first chunk.
    assign w_unused_first = i_first;

    always_comb begin
        w_idx     = 0;
        w_found   = 1'b0;
        w_log     = 0;
        w_span    = 1;
        w_grow    = 1'b1;
        w_cand    = '0;
        w_rem_ext = '0;
        o_mask    = '0;

        // Lowest enabled byte anchors the chunk.
        for (int unsigned b = 0; b < NB; b++) begin
            if (!w_found && i_rem[b]) begin
                w_idx   = b;
                w_found = 1'b1;
            end
        end

        w_rem_ext[NB-1:0] = i_rem;

        if (LegacySplit) begin
            // The whole-store pattern decides once: either the first chunk
            // is the entire legal pattern, or every chunk is a single byte.
            if (i_first) begin
                w_log = 32'(to_size(w_rem_ext, NB));
            end
        end else begin
            // Grow the chunk while it stays aligned and fully enabled. A
            // failing size means every larger size fails too, since the
            // larger chunk contains the smaller one.
            for (int unsigned s = 1; s <= LW; s++) begin
                w_span = 1 << s;
                for (int unsigned b = 0; b < NB; b++) begin
                    w_cand[b] = (b >= w_idx) && (b < w_idx + w_span);
                end
                if (w_grow && (w_idx % w_span == 0) && ((i_rem & w_cand) == w_cand)) begin
                    w_log = s;
                end else begin
                    w_grow = 1'b0;
                end
            end
        end

        w_span = 1 << w_log;
        for (int unsigned b = 0; b < NB; b++) begin
            o_mask[b] = (b >= w_idx) && (b < w_idx + w_span);
        end
    end

    assign o_offset = w_idx[LW-1:0];
    assign o_size   = l15_size_e'(w_log[2:0]);
    assign o_last   = ((i_rem & ~o_mask) == '0);

endmodule

// File: rtl/wt_l15_store_splitter.sv
// Store splitter: turns one word store with arbitrary byte enables into aligned L1.5 chunks.
// Latency: first chunk one cycle after input handshake, then one chunk per cycle.
// Backpressure: chunk outputs hold while out_ready_i is low; in_ready_o drops during a store
//               except on the accepted last chunk, which allows back-to-back stores.
// Ports: clk_i/rst_ni clock and async active-low reset; in_* store request (valid/ready,
//        word address, byte enables, data, tid); out_* chunk stream (valid/ready, byte address,
//        L1.5 size, chunk enables, data, tid, last).
module wt_l15_store_splitter
    import wt_l15_store_splitter_pkg::*;
#(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned AddrWidth   = 40,
    parameter int unsigned TidWidth    = 2,
    parameter bit          LegacySplit = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [AddrWidth-1:0]   in_addr_i,
    input  logic [DataWidth/8-1:0] in_be_i,
    input  logic [DataWidth-1:0]   in_data_i,
    input  logic [TidWidth-1:0]    in_tid_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [AddrWidth-1:0]   out_addr_o,
    output logic [2:0]             out_size_o,
    output logic [DataWidth/8-1:0] out_be_o,
    output logic [DataWidth-1:0]   out_data_o,
    output logic [TidWidth-1:0]    out_tid_o,
    output logic                   out_last_o
);

    localparam int unsigned NB = DataWidth / 8;
    localparam int unsigned LW = $clog2(NB);

    split_state_e            r_state;
    logic [NB-1:0]           r_rem;
    logic                    r_first;
    logic [AddrWidth-LW-1:0] r_addr_hi;
    logic [DataWidth-1:0]    r_data;
    logic [TidWidth-1:0]     r_tid;

    logic [LW-1:0]           w_offset;
    l15_size_e               w_size;
    logic [NB-1:0]           w_mask;
    logic                    w_last;
    logic                    w_out_hs;
    logic                    w_in_hs;
    logic                    w_load;
    logic                    w_unused_addr_lo;

    // The byte offset inside the word comes from the enables, not the address.
    assign w_unused_addr_lo = ^in_addr_i[LW-1:0];

    wt_be_chunk_sel #(
        .NB          (NB),
        .LegacySplit (LegacySplit)
    ) u_chunk_sel (
        .i_rem    (r_rem),
        .i_first  (r_first),
        .o_offset (w_offset),
        .o_size   (w_size),
        .o_mask   (w_mask),
        .o_last   (w_last)
    );

    // Every output derives from registered state only; in_* never reaches out_*.
    assign out_valid_o = (r_state == SPLIT_EMIT);
    assign out_addr_o  = {r_addr_hi, w_offset};
    assign out_size_o  = out_valid_o ? w_size : L15_BYTE;
    assign out_be_o    = out_valid_o ? w_mask : '0;
    assign out_last_o  = out_valid_o & w_last;
    assign out_data_o  = r_data;
    assign out_tid_o   = r_tid;

    assign w_out_hs   = out_valid_o & out_ready_i;
    assign in_ready_o = (r_state == SPLIT_IDLE) | (w_out_hs & out_last_o);
    assign w_in_hs    = in_valid_i & in_ready_o;
    // An all-zero store is consumed without producing any chunk.
    assign w_load     = w_in_hs & (in_be_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= SPLIT_IDLE;
            r_rem     <= '0;
            r_first   <= 1'b0;
            r_addr_hi <= '0;
            r_data    <= '0;
            r_tid     <= '0;
        end else begin
            if (w_out_hs) begin
                r_rem   <= r_rem & ~w_mask;
                r_first <= 1'b0;
                if (w_last) begin
                    r_state <= SPLIT_IDLE;
                end
            end
            // A store taken on the last-chunk cycle overrides the drain above.
            if (w_load) begin
                r_state   <= SPLIT_EMIT;
                r_rem     <= in_be_i;
                r_first   <= 1'b1;
                r_addr_hi <= in_addr_i[AddrWidth-1:LW];
                r_data    <= in_data_i;
                r_tid     <= in_tid_i;
            end
        end
    end

endmodule

// File: tb/tb_wt_l15_store_splitter.sv
// Directed bench: three splitter instances (64-bit greedy, 64-bit legacy, 32-bit greedy)
// share stimulus buses; each instance has its own valid and a chunk log captured on the
// falling edge whenever a chunk handshake is about to occur.
module tb_wt_l15_store_splitter;

    logic        clk;
    logic        rst_n;
    logic        out_rdy;
    logic [39:0] in_addr;
    logic [7:0]  in_be;
    logic [63:0] in_data;
    logic [1:0]  in_tid;

    logic        v0, r0, ov0, olast0;
    logic [39:0] oaddr0;
    logic [2:0]  osize0;
    logic [7:0]  obe0;
    logic [63:0] odata0;
    logic [1:0]  otid0;

    logic        v1, r1, ov1, olast1;
    logic [39:0] oaddr1;
    logic [2:0]  osize1;
    logic [7:0]  obe1;
    logic [63:0] odata1;
    logic [1:0]  otid1;

    logic        v2, r2, ov2, olast2;
    logic [39:0] oaddr2;
    logic [2:0]  osize2;
    logic [3:0]  obe2;
    logic [31:0] odata2;
    logic [1:0]  otid2;

    int n_vec;
    int n_err;

    // Chunk log entry: {addr[39:0], size[2:0], be[7:0], last}
    logic [51:0] q0[$];
    logic [51:0] q1[$];
    logic [51:0] q2[$];

    wt_l15_store_splitter u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(v0), .in_ready_o(r0), .in_addr_i(in_addr), .in_be_i(in_be),
        .in_data_i(in_data), .in_tid_i(in_tid),
        .out_valid_o(ov0), .out_ready_i(out_rdy), .out_addr_o(oaddr0), .out_size_o(osize0),
        .out_be_o(obe0), .out_data_o(odata0), .out_tid_o(otid0), .out_last_o(olast0)
    );

    wt_l15_store_splitter #(.LegacySplit(1'b1)) u_leg (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(v1), .in_ready_o(r1), .in_addr_i(in_addr), .in_be_i(in_be),
        .in_data_i(in_data), .in_tid_i(in_tid),
        .out_valid_o(ov1), .out_ready_i(out_rdy), .out_addr_o(oaddr1), .out_size_o(osize1),
        .out_be_o(obe1), .out_data_o(odata1), .out_tid_o(otid1), .out_last_o(olast1)
    );

    wt_l15_store_splitter #(.DataWidth(32)) u_d32 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(v2), .in_ready_o(r2), .in_addr_i(in_addr), .in_be_i(in_be[3:0]),
        .in_data_i(in_data[31:0]), .in_tid_i(in_tid),
        .out_valid_o(ov2), .out_ready_i(out_rdy), .out_addr_o(oaddr2), .out_size_o(osize2),
        .out_be_o(obe2), .out_data_o(odata2), .out_tid_o(otid2), .out_last_o(olast2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ov0 && out_rdy) q0.push_back({oaddr0, osize0, obe0, olast0});
        if (ov1 && out_rdy) q1.push_back({oaddr1, osize1, obe1, olast1});
        if (ov2 && out_rdy) q2.push_back({oaddr2, osize2, {4'h0, obe2}, olast2});
    end

    // Offers one store to instance sel and returns once it has been taken
    // (ok=1) or the cycle budget ran out (ok=0). Ends at posedge + 1.
    task automatic push_store(input int sel, input logic [39:0] addr, input logic [7:0] be,
                              input logic [63:0] data, input logic [1:0] tid, output bit ok);
        @(posedge clk); #1;
        in_addr = addr; in_be = be; in_data = data; in_tid = tid;
        ok = 1'b0;
        case (sel)
            0:       v0 = 1'b1;
            1:       v1 = 1'b1;
            default: v2 = 1'b1;
        endcase
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = (sel == 0) ? r0 : (sel == 1) ? r1 : r2;
        end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", ov0); end
        n_vec++; if (r0 !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", r0); end
        n_vec++; if (olast0 !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", olast0); end
        n_vec++; if (obe0 !== 8'h00) begin n_err++; $display("FAIL reset_be got %h want 00", obe0); end
        n_vec++; if (oaddr0 !== 40'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", oaddr0); end
        n_vec++; if ({odata0, otid0} !== 66'h0) begin n_err++; $display("FAIL reset_data_tid got %h/%h want 0/0", odata0, otid0); end
        n_vec++; if ({ov1, ov2, r1, r2} !== 4'b0011) begin n_err++; $display("FAIL reset_other_inst got %b want 0011", {ov1, ov2, r1, r2}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if ({ov0, r0} !== 2'b01) begin n_err++; $display("FAIL post_reset_idle got %b want 01", {ov0, r0}); end
    endtask

    task automatic test_full_dword();
        bit ok;
        q0.delete();
        push_store(0, 40'h1000, 8'hFF, 64'h0123_4567_89AB_CDEF, 2'd2, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL full_accept got 0 want 1"); end
        @(negedge clk);
        n_vec++; if ({odata0, otid0} !== {64'h0123_4567_89AB_CDEF, 2'd2}) begin
            n_err++; $display("FAIL full_data_tid got %h/%0d want 0123456789abcdef/2", odata0, otid0);
        end
        repeat (6) @(posedge clk); #1;
        n_vec++; if (q0.size() != 1) begin n_err++; $display("FAIL full_count got %0d want 1", q0.size()); end
        n_vec++; if (q0.size() < 1 || q0[0] !== {40'h1000, 3'b011, 8'hFF, 1'b1}) begin
            n_err++; $display("FAIL full_chunk got %h want %h", (q0.size() > 0) ? q0[0] : 52'h0, {40'h1000, 3'b011, 8'hFF, 1'b1});
        end
    endtask

    task automatic test_greedy_3c();
        logic [51:0] exp [2];
        logic [51:0] got;
        bit ok;
        exp[0] = {40'h2002, 3'b001, 8'h0C, 1'b0};
        exp[1] = {40'h2004, 3'b001, 8'h30, 1'b1};
        q0.delete();
        // Low address bits must be ignored.
        push_store(0, 40'h2005, 8'h3C, 64'h1111_2222_3333_4444, 2'd1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL greedy3c_accept got 0 want 1"); end
        repeat (8) @(posedge clk); #1;
        n_vec++; if (q0.size() != 2) begin n_err++; $display("FAIL greedy3c_count got %0d want 2", q0.size()); end
        for (int k = 0; k < 2; k++) begin
            got = (k < q0.size()) ? q0[k] : 52'h0;
            n_vec++;
            if (got !== exp[k]) begin n_err++; $display("FAIL greedy3c_chunk%0d got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_legacy();
        logic [51:0] exp [6];
        logic [51:0] got;
        bit ok;
        exp[0] = {40'h4002, 3'b000, 8'h04, 1'b0};
        exp[1] = {40'h4003, 3'b000, 8'h08, 1'b0};
        exp[2] = {40'h4004, 3'b000, 8'h10, 1'b0};
        exp[3] = {40'h4005, 3'b000, 8'h20, 1'b1};
        exp[4] = {40'h4004, 3'b010, 8'hF0, 1'b1};
        exp[5] = {40'h4000, 3'b011, 8'hFF, 1'b1};
        q1.delete();
        push_store(1, 40'h4000, 8'h3C, 64'hAAAA_BBBB_CCCC_DDDD, 2'd0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL legacy_accept0 got 0 want 1"); end
        push_store(1, 40'h4000, 8'hF0, 64'h5555_6666_7777_8888, 2'd1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL legacy_accept1 got 0 want 1"); end
        push_store(1, 40'h4000, 8'hFF, 64'h9999_0000_9999_0000, 2'd3, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL legacy_accept2 got 0 want 1"); end
        repeat (6) @(posedge clk); #1;
        n_vec++; if (q1.size() != 6) begin n_err++; $display("FAIL legacy_count got %0d want 6", q1.size()); end
        for (int k = 0; k < 6; k++) begin
            got = (k < q1.size()) ? q1[k] : 52'h0;
            n_vec++;
            if (got !== exp[k]) begin n_err++; $display("FAIL legacy_chunk%0d got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_greedy_7e();
        logic [51:0] exp [4];
        logic [51:0] got;
        bit ok;
        exp[0] = {40'h8001, 3'b000, 8'h02, 1'b0};
        exp[1] = {40'h8002, 3'b001, 8'h0C, 1'b0};
        exp[2] = {40'h8004, 3'b001, 8'h30, 1'b0};
        exp[3] = {40'h8006, 3'b000, 8'h40, 1'b1};
        q0.delete();
        push_store(0, 40'h8000, 8'h7E, 64'hDEAD_BEEF_CAFE_F00D, 2'd3, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL greedy7e_accept got 0 want 1"); end
        repeat (8) @(posedge clk); #1;
        n_vec++; if (q0.size() != 4) begin n_err++; $display("FAIL greedy7e_count got %0d want 4", q0.size()); end
        for (int k = 0; k < 4; k++) begin
            got = (k < q0.size()) ? q0[k] : 52'h0;
            n_vec++;
            if (got !== exp[k]) begin n_err++; $display("FAIL greedy7e_chunk%0d got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_zero_be();
        bit ok;
        q0.delete();
        push_store(0, 40'h9000, 8'h00, 64'h1, 2'd0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL zero_accept got 0 want 1"); end
        repeat (5) @(posedge clk); #1;
        n_vec++; if (q0.size() != 0) begin n_err++; $display("FAIL zero_no_output got %0d chunks want 0", q0.size()); end
        n_vec++; if ({ov0, r0} !== 2'b01) begin n_err++; $display("FAIL zero_idle got %b want 01", {ov0, r0}); end
    endtask

    task automatic test_dw32();
        logic [51:0] exp [3];
        logic [51:0] got;
        bit ok;
        exp[0] = {40'h3000, 3'b010, 8'h0F, 1'b1};
        exp[1] = {40'h3004, 3'b000, 8'h01, 1'b0};
        exp[2] = {40'h3006, 3'b000, 8'h04, 1'b1};
        q2.delete();
        push_store(2, 40'h3000, 8'h0F, 64'h0, 2'd0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL dw32_accept0 got 0 want 1"); end
        push_store(2, 40'h3007, 8'h05, 64'h0, 2'd1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL dw32_accept1 got 0 want 1"); end
        repeat (6) @(posedge clk); #1;
        n_vec++; if (q2.size() != 3) begin n_err++; $display("FAIL dw32_count got %0d want 3", q2.size()); end
        for (int k = 0; k < 3; k++) begin
            got = (k < q2.size()) ? q2[k] : 52'h0;
            n_vec++;
            if (got !== exp[k]) begin n_err++; $display("FAIL dw32_chunk%0d got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        q0.delete();
        push_store(0, 40'h5000, 8'h7E, 64'h0000_1111_2222_3333, 2'd1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_accept got 0 want 1"); end
        // First chunk drains; stall the second one.
        @(posedge clk); #1;
        out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({ov0, oaddr0, osize0, obe0, olast0} !== {1'b1, 40'h5002, 3'b001, 8'h0C, 1'b0}) begin
                n_err++; $display("FAIL bp_hold%0d got v=%b a=%h s=%b be=%h l=%b want 1/5002/001/0c/0",
                                  c, ov0, oaddr0, osize0, obe0, olast0);
            end
        end
        @(posedge clk); #1;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Last chunk is presenting: offer the next store now.
        in_addr = 40'h6000; in_be = 8'hFF; in_data = 64'hA5A5_5A5A_0F0F_F0F0; in_tid = 2'd3;
        v0 = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({r0, oaddr0, obe0, olast0} !== {1'b1, 40'h5006, 8'h40, 1'b1}) begin
            n_err++; $display("FAIL b2b_last_cycle got r=%b a=%h be=%h l=%b want 1/5006/40/1", r0, oaddr0, obe0, olast0);
        end
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ov0, oaddr0, osize0, obe0, olast0, odata0, otid0} !==
            {1'b1, 40'h6000, 3'b011, 8'hFF, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 2'd3}) begin
            n_err++; $display("FAIL b2b_no_bubble got v=%b a=%h s=%b be=%h l=%b d=%h t=%0d want 1/6000/011/ff/1/a5a55a5a0f0ff0f0/3",
                              ov0, oaddr0, osize0, obe0, olast0, odata0, otid0);
        end
        repeat (4) @(posedge clk); #1;
        n_vec++; if (q0.size() != 5) begin n_err++; $display("FAIL b2b_count got %0d want 5", q0.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        q0.delete();
        push_store(0, 40'h7000, 8'h7E, 64'h7777_7777_7777_7777, 2'd2, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_accept got 0 want 1"); end
        @(posedge clk); #1;
        // Second chunk is presenting.
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ov0, olast0, obe0} !== {1'b0, 1'b0, 8'h00}) begin
            n_err++; $display("FAIL rstmid_immediate got v=%b l=%b be=%h want 0/0/00", ov0, olast0, obe0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (r0 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", r0); end
        repeat (5) @(posedge clk); #1;
        n_vec++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL rstmid_no_stale got %b want 0", ov0); end
        n_vec++; if (q0.size() != 1) begin n_err++; $display("FAIL rstmid_count got %0d want 1", q0.size()); end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        out_rdy = 1'b1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        in_addr = '0; in_be = '0; in_data = '0; in_tid = '0;

        test_reset();
        test_full_dword();
        test_greedy_3c();
        test_legacy();
        test_greedy_7e();
        test_zero_be();
        test_dw32();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
